// File: rtl/chess_game_ctrl_if.sv
// ----------------------------------------------------------------------------
// chess_game_ctrl_if
// Signal bundle between the chess clock controller and its surroundings
// (debounced buttons, the two countdown timers and the display).
//   start_req/pause_req/press1/press2 : one-cycle debounced button pulses
//   zero1/zero2                       : timer-at-zero levels (White/Black)
//   load/tick1/tick2/inc1/inc2        : one-cycle timer control pulses
//   player/state/game_over/winner     : game status
//   move_count                        : completed plies (MOVE_W bits)
// slave  : the controller's view
// master : the environment's view (buttons + timers)
// ----------------------------------------------------------------------------
interface chess_game_ctrl_if #(
  parameter int MOVE_W = 8
);
  logic              start_req;
  logic              pause_req;
  logic              press1;
  logic              press2;
  logic              zero1;
  logic              zero2;
  logic              load;
  logic              tick1;
  logic              tick2;
  logic              inc1;
  logic              inc2;
  logic              player;
  logic [2:0]        state;
  logic              game_over;
  logic              winner;
  logic [MOVE_W-1:0] move_count;

  modport slave (
    input  start_req, pause_req, press1, press2, zero1, zero2,
    output load, tick1, tick2, inc1, inc2, player, state, game_over,
           winner, move_count
  );

  modport master (
    output start_req, pause_req, press1, press2, zero1, zero2,
    input  load, tick1, tick2, inc1, inc2, player, state, game_over,
           winner, move_count
  );
endinterface

// File: rtl/chess_game_ctrl.sv
// ----------------------------------------------------------------------------
// chess_game_ctrl
// Two-player chess clock controller. Sequences IDLE -> RUN_W/RUN_B with
// pause and game-over handling, paces timer decrements every TICK_DIV run
// cycles, issues a bonus increment to the side that just moved and counts
// completed plies (saturating).
//   clk_one : single clock, all state changes on its rising edge
//   reset   : synchronous, active-high
//   bus     : chess_game_ctrl_if.slave (buttons, timer zero flags in;
//             timer controls and game status out, all registered)
// ----------------------------------------------------------------------------
module chess_game_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int MOVE_W   = 8
) (
  input  logic                clk_one,
  input  logic                reset,
  chess_game_ctrl_if.slave    bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_W   = 3'd1,
    ST_RUN_B   = 3'd2,
    ST_PAUSE_W = 3'd3,
    ST_PAUSE_B = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              load_r,      load_nxt_s;
  logic              tick1_r,     tick1_nxt_s;
  logic              tick2_r,     tick2_nxt_s;
  logic              inc1_r,      inc1_nxt_s;
  logic              inc2_r,      inc2_nxt_s;
  logic              player_r,    player_nxt_s;
  logic              game_over_r, game_over_nxt_s;
  logic              winner_r,    winner_nxt_s;
  logic [MOVE_W-1:0] move_r,      move_nxt_s;

  logic              start_s;
  logic              sw_w_s;
  logic              sw_b_s;
  logic              run_s;

  // Ply counter sticks at all-ones instead of wrapping.
  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(MOVE_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // State register.
  always_ff @(posedge clk_one) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Timer zero flags are stale while the timers reload.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (bus.start_req) state_nxt_s = ST_RUN_W;
        else               state_nxt_s = state_r;
      end
      ST_RUN_W: begin
        if (bus.zero1 && !load_r) state_nxt_s = ST_OVER;
        else if (bus.press1)      state_nxt_s = ST_RUN_B;
        else if (bus.pause_req)   state_nxt_s = ST_PAUSE_W;
        else                      state_nxt_s = ST_RUN_W;
      end
      ST_RUN_B: begin
        if (bus.zero2 && !load_r) state_nxt_s = ST_OVER;
        else if (bus.press2)      state_nxt_s = ST_RUN_W;
        else if (bus.pause_req)   state_nxt_s = ST_PAUSE_B;
        else                      state_nxt_s = ST_RUN_B;
      end
      ST_PAUSE_W: begin
        if (bus.pause_req || bus.start_req) state_nxt_s = ST_RUN_W;
        else                                state_nxt_s = ST_PAUSE_W;
      end
      ST_PAUSE_B: begin
        if (bus.pause_req || bus.start_req) state_nxt_s = ST_RUN_B;
        else                                state_nxt_s = ST_PAUSE_B;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and tick counter.
  // cnt_r holds the number of run cycles already finished in the current
  // tick period, so a tick is due in a cycle entered with cnt == TICK_DIV-1.
  always_comb begin
    start_s = ((state_r == ST_IDLE) || (state_r == ST_OVER)) && bus.start_req;
    sw_w_s  = (state_r == ST_RUN_W) && (state_nxt_s == ST_RUN_B);
    sw_b_s  = (state_r == ST_RUN_B) && (state_nxt_s == ST_RUN_W);
    run_s   = (state_r == ST_RUN_W) || (state_r == ST_RUN_B);

    cnt_nxt_s = cnt_r;
    if (start_s || sw_w_s || sw_b_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (run_s && (state_nxt_s != ST_OVER)) begin
      if (cnt_r == CNT_LAST) cnt_nxt_s = {CNT_W{1'b0}};
      else                   cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end

    load_nxt_s  = start_s;
    inc1_nxt_s  = sw_w_s;
    inc2_nxt_s  = sw_b_s;
    // A tick falling on a side switch is dropped.
    tick1_nxt_s = (state_nxt_s == ST_RUN_W) && (cnt_nxt_s == CNT_LAST) && !sw_b_s;
    tick2_nxt_s = (state_nxt_s == ST_RUN_B) && (cnt_nxt_s == CNT_LAST) && !sw_w_s;

    player_nxt_s    = (state_nxt_s == ST_RUN_B) || (state_nxt_s == ST_PAUSE_B);
    game_over_nxt_s = (state_nxt_s == ST_OVER);

    winner_nxt_s = winner_r;
    if (start_s) begin
      winner_nxt_s = 1'b0;
    end else if (run_s && (state_nxt_s == ST_OVER)) begin
      // The side whose flag fell loses.
      winner_nxt_s = (state_r == ST_RUN_W);
    end else begin
      winner_nxt_s = winner_r;
    end

    move_nxt_s = move_r;
    if (start_s) begin
      move_nxt_s = {MOVE_W{1'b0}};
    end else if (sw_w_s || sw_b_s) begin
      move_nxt_s = sat_inc(move_r);
    end else begin
      move_nxt_s = move_r;
    end
  end

  // Output and tick counter registers.
  always_ff @(posedge clk_one) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      load_r      <= 1'b0;
      tick1_r     <= 1'b0;
      tick2_r     <= 1'b0;
      inc1_r      <= 1'b0;
      inc2_r      <= 1'b0;
      player_r    <= 1'b0;
      game_over_r <= 1'b0;
      winner_r    <= 1'b0;
      move_r      <= {MOVE_W{1'b0}};
    end else begin
      cnt_r       <= cnt_nxt_s;
      load_r      <= load_nxt_s;
      tick1_r     <= tick1_nxt_s;
      tick2_r     <= tick2_nxt_s;
      inc1_r      <= inc1_nxt_s;
      inc2_r      <= inc2_nxt_s;
      player_r    <= player_nxt_s;
      game_over_r <= game_over_nxt_s;
      winner_r    <= winner_nxt_s;
      move_r      <= move_nxt_s;
    end
  end

  assign bus.load       = load_r;
  assign bus.tick1      = tick1_r;
  assign bus.tick2      = tick2_r;
  assign bus.inc1       = inc1_r;
  assign bus.inc2       = inc2_r;
  assign bus.player     = player_r;
  assign bus.state      = state_r;
  assign bus.game_over  = game_over_r;
  assign bus.winner     = winner_r;
  assign bus.move_count = move_r;

endmodule

// File: tb/tb_chess_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_chess_game_ctrl
// Directed self-checking bench for chess_game_ctrl (TICK_DIV=4, MOVE_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_chess_game_ctrl;

  logic clk_one;
  logic reset;
  int   n_cmp;
  int   n_err;

  chess_game_ctrl_if #(.MOVE_W(8)) bus ();

  chess_game_ctrl #(.TICK_DIV(4), .MOVE_W(8)) dut (
    .clk_one (clk_one),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_one = 1'b0;
  always #5 clk_one = ~clk_one;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_one);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start_req = 1'b0;
    bus.pause_req = 1'b0;
    bus.press1    = 1'b0;
    bus.press2    = 1'b0;
    bus.zero1     = 1'b0;
    bus.zero2     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"},  bus.state,      32'd0);
    check_val({tag, "_player"}, bus.player,     32'd0);
    check_val({tag, "_load"},   bus.load,       32'd0);
    check_val({tag, "_tick1"},  bus.tick1,      32'd0);
    check_val({tag, "_tick2"},  bus.tick2,      32'd0);
    check_val({tag, "_inc1"},   bus.inc1,       32'd0);
    check_val({tag, "_inc2"},   bus.inc2,       32'd0);
    check_val({tag, "_over"},   bus.game_over,  32'd0);
    check_val({tag, "_winner"}, bus.winner,     32'd0);
    check_val({tag, "_moves"},  bus.move_count, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check_all_zero("reset");

    // Start: load in cycle 1, tick1 in cycles 4, 8, 12, tick2 never.
    reset = 1'b0;
    bus.start_req = 1'b1;
    step();
    bus.start_req = 1'b0;
    check_val("start_state", bus.state, 32'd1);
    for (int c = 1; c <= 12; c++) begin
      check_val("run_load",  bus.load,  (c == 1)     ? 32'd1 : 32'd0);
      check_val("run_tick1", bus.tick1, (c % 4 == 0) ? 32'd1 : 32'd0);
      check_val("run_tick2", bus.tick2, 32'd0);
      if (c < 12) step();
    end

    // White moves: RUN_B, bonus to White, tick2 on 4th Black run cycle.
    bus.press1 = 1'b1;
    step();
    bus.press1 = 1'b0;
    check_val("sw_state",  bus.state,      32'd2);
    check_val("sw_player", bus.player,     32'd1);
    check_val("sw_moves",  bus.move_count, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check_val("b_inc1",  bus.inc1,  (k == 1) ? 32'd1 : 32'd0);
      check_val("b_tick2", bus.tick2, (k == 4) ? 32'd1 : 32'd0);
      check_val("b_tick1", bus.tick1, 32'd0);
      if (k < 4) begin
        bus.press1 = (k == 2);   // wrong side's button, ignored
        step();
        bus.press1 = 1'b0;
      end
    end
    check_val("b_ign_state", bus.state,      32'd2);
    check_val("b_ign_moves", bus.move_count, 32'd1);

    // Black moves back.
    bus.press2 = 1'b1;
    step();
    check_val("sw2_state",  bus.state,      32'd1);
    check_val("sw2_inc2",   bus.inc2,       32'd1);
    check_val("sw2_moves",  bus.move_count, 32'd2);
    check_val("sw2_player", bus.player,     32'd0);
    // press2 still high: ignored in RUN_W.
    step();
    bus.press2 = 1'b0;
    check_val("w_ign_state", bus.state,      32'd1);
    check_val("w_ign_moves", bus.move_count, 32'd2);
    check_val("w_ign_inc2",  bus.inc2,       32'd0);

    // Pause after 2 White run cycles, 10 paused cycles, resume.
    bus.pause_req = 1'b1;
    step();
    bus.pause_req = 1'b0;
    for (int p = 1; p <= 10; p++) begin
      check_val("pause_state", bus.state, 32'd3);
      check_val("pause_tick1", bus.tick1, 32'd0);
      check_val("pause_tick2", bus.tick2, 32'd0);
      bus.press1    = (p == 3);
      bus.start_req = (p == 10);
      step();
    end
    clear_inputs();
    check_val("resume_state", bus.state, 32'd1);
    check_val("resume_tick1", bus.tick1, 32'd0);
    step();
    check_val("resume_tick1b", bus.tick1,      32'd1);
    check_val("resume_moves",  bus.move_count, 32'd2);

    // Flag fall beats move in the same cycle.
    bus.zero1  = 1'b1;
    bus.press1 = 1'b1;
    step();
    check_val("over_state",  bus.state,      32'd5);
    check_val("over_flag",   bus.game_over,  32'd1);
    check_val("over_winner", bus.winner,     32'd1);
    check_val("over_inc1",   bus.inc1,       32'd0);
    check_val("over_moves",  bus.move_count, 32'd2);
    check_val("over_tick1",  bus.tick1,      32'd0);
    // Inputs other than start ignored in OVER.
    bus.zero1 = 1'b0;
    step();
    bus.press1 = 1'b0;
    check_val("over_hold", bus.state, 32'd5);

    // Restart; zero flag during the load cycle is ignored.
    bus.start_req = 1'b1;
    step();
    bus.start_req = 1'b0;
    check_val("rst2_load",  bus.load,       32'd1);
    check_val("rst2_over",  bus.game_over,  32'd0);
    check_val("rst2_moves", bus.move_count, 32'd0);
    bus.zero1 = 1'b1;
    step();
    bus.zero1 = 1'b0;
    check_val("load_zero_ign", bus.state, 32'd1);

    // 255 plies, then one more: saturates.
    for (int i = 0; i < 255; i++) begin
      bus.press1 = (i % 2 == 0);
      bus.press2 = (i % 2 == 1);
      step();
    end
    clear_inputs();
    check_val("sat255_moves", bus.move_count, 32'd255);
    check_val("sat255_state", bus.state,      32'd2);
    bus.press2 = 1'b1;
    step();
    bus.press2 = 1'b0;
    check_val("sat_moves", bus.move_count, 32'd255);
    check_val("sat_inc2",  bus.inc2,       32'd1);
    check_val("sat_state", bus.state,      32'd1);

    // Black flag falls: White wins.
    bus.press1 = 1'b1;
    step();
    bus.press1 = 1'b0;
    bus.zero2  = 1'b1;
    step();
    bus.zero2  = 1'b0;
    check_val("over2_state",  bus.state,  32'd5);
    check_val("over2_winner", bus.winner, 32'd0);
    check_val("over2_flag",   bus.game_over, 32'd1);

    // Reset in PAUSE_B with 7 plies.
    bus.start_req = 1'b1;
    step();
    bus.start_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.press1 = (i % 2 == 0);
      bus.press2 = (i % 2 == 1);
      step();
    end
    clear_inputs();
    bus.pause_req = 1'b1;
    step();
    bus.pause_req = 1'b0;
    check_val("pb_state",  bus.state,      32'd4);
    check_val("pb_moves",  bus.move_count, 32'd7);
    check_val("pb_player", bus.player,     32'd1);
    reset = 1'b1;
    bus.start_req = 1'b1;   // overridden by reset
    step();
    bus.start_req = 1'b0;
    check_all_zero("midreset");
    reset = 1'b0;
    step();
    check_val("idle_hold", bus.state, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
